conv1_sched: RTL
================

Name: conv1_sched

Overview:
Layer controller for the conv1 engine.
- Accepts a start request and fires the conv1 trigger pulse.
- Tracks each per-channel out_valid/out_chan result and serialises the 14x13 x 24-bit result plane of that channel, one pixel per beat.
- Requantises each pixel to uint8 and writes it into the feature-map memory feeding the next layer, under write backpressure.
- Reports done plus sticky error flags (timeout, channel order, overrun) to the top-level sequencer.

Parameters:
OUT_H, 14, conv1 output rows
OUT_W, 13, conv1 output columns
CHAN, 10, conv1 output channels
SHIFT, 4, arithmetic right shift applied before saturation
TIMEOUT, 4096, max cycles spent in TRIG/WAIT_CH waiting for one channel's out_valid edge
ADDR_W, 11, feature-map address width; must hold CHAN*OUT_H*OUT_W-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a full conv1 pass; sampled only in IDLE
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cycle pulse at end of pass, success or error
err_timeout  out  1  sticky: channel edge not seen within TIMEOUT
err_chan  out  1  sticky: conv_chan differed from expected channel at edge
err_overrun  out  1  sticky: new conv_valid edge arrived while draining
conv_trigger  out  1  one-cycle start pulse to conv1
conv_valid  in  1  conv1 out_valid
conv_chan  in  4  conv1 out_chan
conv_row  out  4  out_buff row select for external pixel mux
conv_col  out  4  out_buff column select
conv_pix  in  24  signed out_buff[conv_row][conv_col], combinational
fm_we  out  1  write request, held until accepted
fm_ready  in  1  memory accepts write when fm_we && fm_ready
fm_addr  out  ADDR_W  ch*OUT_H*OUT_W + row*OUT_W + col
fm_wdata  out  8  requantised pixel

Behaviour:
- Reset (async, rst_n low): state IDLE, all outputs 0, counters 0, conv_valid edge register 0. A reset mid-pass aborts with no done pulse; the pass restarts only on a new start.
- States: IDLE, TRIG, WAIT_CH, DRAIN, FLUSH, DONE.
- IDLE:
  - start=1 at a posedge moves to TRIG, sets busy, clears all err_* flags and clears ch.
  - start while busy is ignored.
- TRIG: conv_trigger=1 for exactly this cycle; go to WAIT_CH.
- Timeout counter:
  - Resets on entry to TRIG and on every transition into WAIT_CH from DRAIN.
  - Counts every cycle spent in TRIG or WAIT_CH.
- WAIT_CH:
  - Edge = conv_valid & ~conv_valid_q.
  - On edge: if conv_chan != ch, set err_chan; still drain using the expected ch. Go to DRAIN with row=col=0.
  - If the counter reaches TIMEOUT-1 with no edge: set err_timeout and go to FLUSH.
- DRAIN:
  - Output stage (fm_we/fm_addr/fm_wdata) is registered.
  - The stage loads when !fm_we || fm_ready, capturing the current row/col/ch address and requant(conv_pix).
  - row/col advance only on a load: col wraps at OUT_W-1 to 0 and increments row.
  - After loading (OUT_H-1, OUT_W-1): increment ch. If ch was CHAN-1, go to FLUSH; else go to WAIT_CH.
  - Exactly OUT_H*OUT_W = 182 writes per channel.
- Overrun: a conv_valid edge seen in DRAIN or FLUSH sets err_overrun. That edge is not counted; the missed channel is later caught by timeout.
- FLUSH: wait until fm_we=0 or fm_ready=1 (last write accepted); go to DONE.
- DONE: done=1 and busy=1 for one cycle; next state IDLE, busy=0.
- Requant:
  - If conv_pix[23]=1, result is 0.
  - Else v = conv_pix >>> SHIFT; result is 255 if v > 255, else v[7:0].
- Latency:
  - start accepted at edge N: conv_trigger high in cycle N+1.
  - First fm_we: the cycle after the drain's first load edge, i.e. 2 cycles after the conv_valid edge is sampled.
  - With fm_ready tied 1, one channel drains in 182 cycles.
- fm_we deasserts the cycle after its last accepted beat when no new load occurs.
- fm_addr/fm_wdata are stable while fm_we=1 && fm_ready=0.

Decomposition:
- Shared package npu_pkg holds:
  - OUT1_H/OUT1_W/CHAN constants
  - the conv1_sched state enum
  - function sat_u8(signed [23:0], shift)
- Natural sub-module: fm_requant (combinational shift/ReLU-guard/saturate), reused by later layer controllers.
- The pixel mux selected by conv_row/conv_col stays outside the block.

Test Plan:
- Nominal pass, fm_ready=1, conv model produces channels 0..9 every 400 cycles with pix=row*16+col+ch*4096 -> 1820 writes, fm_addr 0..1819 in order, fm_wdata=min((pix>>4),255), single done, no errors.
- Requant edges: pix=0x000123 -> 0x12; pix=0x000FFF -> 0xFF; pix=0x010000 -> 0xFF; pix=0x800010 -> 0x00.
- Backpressure: fm_ready toggling 1,0,0 repeatedly -> no write lost or duplicated, data/addr held while stalled, total 1820 accepted writes.
- Channel error: conv_chan=3 delivered when 2 expected -> err_chan=1, data written at ch=2 base address 364, pass completes with done.
- Timeout/overrun:
  - conv model stops after channel 4 -> err_timeout after 4096 cycles of waiting, done pulse, busy drops.
  - A second conv_valid edge 50 cycles into a drain with fm_ready=1 -> err_overrun=1.
- Reset/start corner: rst_n low mid-DRAIN -> all outputs 0 asynchronously, no done; start held high throughout the pass -> exactly one pass, and a new pass starts the cycle after done.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: conv1 geometry, conv1_sched state encoding and the
// uint8 requantisation helper used by all layer controllers.
package npu_pkg;

  localparam int unsigned OUT1_H = 14;
  localparam int unsigned OUT1_W = 13;
  localparam int unsigned CHAN   = 10;
  localparam int unsigned PIX_W  = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_CH,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } conv1_state_e;

  // Negative pixels clamp to 0; positive ones are shifted then saturated to 255.
  function automatic logic [7:0] sat_u8(input logic signed [PIX_W-1:0] pix,
                                        input int unsigned shift);
    logic signed [PIX_W-1:0] v;
    logic [7:0] res;
    v = pix >>> shift;
    if (pix[PIX_W-1]) begin
      res = 8'd0;
    end else if (v > 24'sd255) begin
      res = 8'hFF;
    end else begin
      res = v[7:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fm_requant.sv
// Combinational requantiser: signed 24-bit accumulator to uint8 feature-map pixel.
module fm_requant
  import npu_pkg::*;
#(
  parameter int unsigned SHIFT = 4
) (
  input  logic signed [PIX_W-1:0] pix_i,
  output logic        [7:0]       q_c
);

  assign q_c = sat_u8(pix_i, SHIFT);

endmodule

// File: rtl/conv1_sched.sv
// conv1 layer controller: triggers conv1, drains each channel's result plane
// pixel by pixel into the feature-map memory and reports done/error status.
module conv1_sched #(
  parameter int unsigned OUT_H   = 14,
  parameter int unsigned OUT_W   = 13,
  parameter int unsigned CHAN    = 10,
  parameter int unsigned SHIFT   = 4,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned ADDR_W  = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout,
  output logic                     err_chan,
  output logic                     err_overrun,
  output logic                     conv_trigger,
  input  logic                     conv_valid,
  input  logic [3:0]               conv_chan,
  output logic [3:0]               conv_row,
  output logic [3:0]               conv_col,
  input  logic signed [23:0]       conv_pix,
  output logic                     fm_we,
  input  logic                     fm_ready,
  output logic [ADDR_W-1:0]        fm_addr,
  output logic [7:0]               fm_wdata
);

  import npu_pkg::*;

  localparam int unsigned RC_W  = 4;
  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam int unsigned PLANE = OUT_H * OUT_W;

  conv1_state_e state_q, state_d;
  logic [RC_W-1:0]   ch_q, ch_d, row_q, row_d, col_q, col_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              cv_q;
  logic              busy_q, busy_d, done_q, done_d, trig_q, trig_d;
  logic              etmo_q, etmo_d, ech_q, ech_d, eovr_q, eovr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_c;
  logic [7:0]        wdata_q, wdata_d, rq_c;
  logic              cv_edge_c, load_c, last_pix_c;

  fm_requant #(.SHIFT(SHIFT)) u_requant (
    .pix_i (conv_pix),
    .q_c   (rq_c)
  );

  assign cv_edge_c  = conv_valid & ~cv_q;
  assign load_c     = ~we_q | fm_ready;
  assign last_pix_c = (row_q == RC_W'(OUT_H - 1)) && (col_q == RC_W'(OUT_W - 1));
  assign addr_c     = ADDR_W'(ch_q) * ADDR_W'(PLANE) + ADDR_W'(row_q) * ADDR_W'(OUT_W)
                    + ADDR_W'(col_q);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    row_d   = row_q;
    col_d   = col_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    trig_d  = 1'b0;
    etmo_d  = etmo_q;
    ech_d   = ech_q;
    eovr_d  = eovr_q;
    we_d    = we_q & ~fm_ready;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_TRIG;
          trig_d  = 1'b1;
          busy_d  = 1'b1;
          etmo_d  = 1'b0;
          ech_d   = 1'b0;
          eovr_d  = 1'b0;
          ch_d    = '0;
          tmo_d   = '0;
        end
      end
      S_TRIG: begin
        state_d = S_WAIT_CH;
        tmo_d   = tmo_q + TMO_W'(1);
      end
      S_WAIT_CH: begin
        if (cv_edge_c) begin
          // A mislabelled channel is flagged but still stored at the expected slot.
          if (conv_chan != ch_q) ech_d = 1'b1;
          state_d = S_DRAIN;
          row_d   = '0;
          col_d   = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          etmo_d  = 1'b1;
          state_d = S_FLUSH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DRAIN: begin
        if (cv_edge_c) eovr_d = 1'b1;
        if (load_c) begin
          we_d    = 1'b1;
          addr_d  = addr_c;
          wdata_d = rq_c;
          if (col_q == RC_W'(OUT_W - 1)) begin
            col_d = '0;
            row_d = row_q + RC_W'(1);
          end else begin
            col_d = col_q + RC_W'(1);
          end
          if (last_pix_c) begin
            ch_d  = ch_q + RC_W'(1);
            row_d = '0;
            tmo_d = '0;
            state_d = (ch_q == RC_W'(CHAN - 1)) ? S_FLUSH : S_WAIT_CH;
          end
        end
      end
      S_FLUSH: begin
        if (cv_edge_c) eovr_d = 1'b1;
        if (load_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tmo_q   <= '0;
      cv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      trig_q  <= 1'b0;
      etmo_q  <= 1'b0;
      ech_q   <= 1'b0;
      eovr_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tmo_q   <= tmo_d;
      cv_q    <= conv_valid;
      busy_q  <= busy_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
      etmo_q  <= etmo_d;
      ech_q   <= ech_d;
      eovr_q  <= eovr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign conv_trigger = trig_q;
  assign err_timeout  = etmo_q;
  assign err_chan     = ech_q;
  assign err_overrun  = eovr_q;
  assign conv_row     = row_q;
  assign conv_col     = col_q;
  assign fm_we        = we_q;
  assign fm_addr      = addr_q;
  assign fm_wdata     = wdata_q;

endmodule
